// File: rtl/mem_port_arbiter.sv
// Single 64-bit memory port shared between instruction fetch and data access.
// Data wins conflicts except when fetch has lost STARVE_LIMIT contested grants
// in a row. One access is in flight at a time; misaligned requests are answered
// with an error without touching memory, and a stuck memory is abandoned after
// TIMEOUT cycles.

// Load data formatter: moves the addressed lanes down to bit 0 and extends
// according to the RV64 func3 encoding.
module mem_port_arbiter_ld_fmt (
    input  logic [63:0] rdata,
    input  logic [2:0]  off,
    input  logic [2:0]  size,
    output logic [63:0] data
);

    logic [63:0] sh;

    // Right-align the addressed lanes, then sign/zero-extend.
    always_comb begin
        sh   = rdata >> {off, 3'b000};
        data = sh;
        case (size)
            3'd0:    data = {{56{sh[7]}},  sh[7:0]};
            3'd1:    data = {{48{sh[15]}}, sh[15:0]};
            3'd2:    data = {{32{sh[31]}}, sh[31:0]};
            3'd4:    data = {56'd0, sh[7:0]};
            3'd5:    data = {48'd0, sh[15:0]};
            3'd6:    data = {32'd0, sh[31:0]};
            default: data = sh;
        endcase
    end

endmodule

module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 2,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst,
    // fetch requester
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    // data requester
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [2:0]  d_size,
    input  logic [63:0] d_wdata,
    output logic        d_valid,
    output logic [63:0] d_rdata,
    output logic        d_err,
    // pipeline stalls
    output logic        stall_if,
    output logic        stall_mem,
    // memory port
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [7:0]  m_be,
    output logic [63:0] m_wdata,
    input  logic        m_ready,
    input  logic [63:0] m_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    // What the response path needs to know about the access in flight.
    typedef struct packed {
        logic       we;
        logic [2:0] size;
        logic [2:0] off;
    } acc_ctx_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

    state_t      state, state_n;
    logic [3:0]  starve_cnt;
    logic [7:0]  wait_cnt;
    acc_ctx_t    ctx;

    logic        grant_if, grant_d;
    logic        done, tmo;
    logic        if_mis, d_mis;
    logic [7:0]  size_mask, d_be;
    logic [63:0] st_data, ld_data;

    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = d_req & ~d_valid;

    // Alignment: fetch is word aligned, data is aligned to its own size; size 7 is illegal.
    always_comb begin
        if_mis = |if_addr[1:0];
        d_mis  = 1'b0;
        case (d_size)
            3'd0, 3'd4: d_mis = 1'b0;
            3'd1, 3'd5: d_mis = d_addr[0];
            3'd2, 3'd6: d_mis = |d_addr[1:0];
            3'd3:       d_mis = |d_addr[2:0];
            default:    d_mis = 1'b1;
        endcase
    end

    // Byte-lane placement of a data access within the doubleword.
    always_comb begin
        size_mask = 8'h01;
        case (d_size[1:0])
            2'd0: size_mask = 8'h01;
            2'd1: size_mask = 8'h03;
            2'd2: size_mask = 8'h0F;
            2'd3: size_mask = 8'hFF;
        endcase
        d_be    = size_mask << d_addr[2:0];
        st_data = d_wdata << {d_addr[2:0], 3'b000};
    end

    mem_port_arbiter_ld_fmt u_ld_fmt (
        .rdata (m_rdata),
        .off   (ctx.off),
        .size  (ctx.size),
        .data  (ld_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // Arbitration and access sequencing; misaligned grants stay in IDLE.
    always_comb begin
        state_n  = state;
        grant_if = 1'b0;
        grant_d  = 1'b0;
        done     = 1'b0;
        tmo      = 1'b0;
        case (state)
            IDLE: begin
                if (if_req && (!d_req || starve_cnt == STARVE_MAX)) grant_if = 1'b1;
                else if (d_req)                                     grant_d  = 1'b1;
                if (grant_if && !if_mis) state_n = BUSY_IF;
                if (grant_d && !d_mis)   state_n = BUSY_D;
            end
            BUSY_IF, BUSY_D: begin
                if (m_ready) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    tmo     = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Counts data grants that beat a waiting fetch; any fetch grant clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (grant_if) begin
            starve_cnt <= '0;
        end else if (grant_d && if_req && starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Cycles spent waiting for m_ready in the current access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                wait_cnt <= '0;
        else if (done || tmo)    wait_cnt <= '0;
        else if (state != IDLE)  wait_cnt <= wait_cnt + 8'd1;
    end

    // Memory port: loaded on an aligned grant, held until completion or timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_be    <= '0;
            m_wdata <= '0;
            ctx     <= '0;
        end else if (grant_if && !if_mis) begin
            m_req   <= 1'b1;
            m_we    <= 1'b0;
            m_addr  <= {if_addr[31:3], 3'b000};
            m_be    <= if_addr[2] ? 8'hF0 : 8'h0F;
            m_wdata <= '0;
            ctx     <= '{we: 1'b0, size: 3'd6, off: {if_addr[2], 2'b00}};
        end else if (grant_d && !d_mis) begin
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_addr  <= {d_addr[31:3], 3'b000};
            m_be    <= d_be;
            m_wdata <= d_we ? st_data : 64'd0;
            ctx     <= '{we: d_we, size: d_size, off: d_addr[2:0]};
        end else if (done || tmo) begin
            m_req   <= 1'b0;
        end
    end

    // Completion pulses; errors (misalignment, timeout) return zero data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_valid <= 1'b0;
            if_err   <= 1'b0;
            if_rdata <= '0;
            d_valid  <= 1'b0;
            d_err    <= 1'b0;
            d_rdata  <= '0;
        end else begin
            if_valid <= 1'b0;
            if_err   <= 1'b0;
            d_valid  <= 1'b0;
            d_err    <= 1'b0;
            if (grant_if && if_mis) begin
                if_valid <= 1'b1;
                if_err   <= 1'b1;
                if_rdata <= '0;
            end
            if (grant_d && d_mis) begin
                d_valid <= 1'b1;
                d_err   <= 1'b1;
                d_rdata <= '0;
            end
            if (state == BUSY_IF && (done || tmo)) begin
                if_valid <= 1'b1;
                if_err   <= tmo;
                if_rdata <= tmo ? 32'd0 : (ctx.off[2] ? m_rdata[63:32] : m_rdata[31:0]);
            end
            if (state == BUSY_D && (done || tmo)) begin
                d_valid <= 1'b1;
                d_err   <= tmo;
                d_rdata <= (tmo || ctx.we) ? 64'd0 : ld_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single accesses plus hand-written
// sequences for starvation, timeout and reset mid-access. Responses are
// checked through per-requester scoreboard queues.
module tb_mem_port_arbiter;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_valid, if_err;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [2:0]  d_size = '0;
    logic [63:0] d_wdata = '0;
    logic        d_valid, d_err;
    logic [63:0] d_rdata;
    logic        stall_if, stall_mem;
    logic        m_req, m_we;
    logic [31:0] m_addr;
    logic [7:0]  m_be;
    logic [63:0] m_wdata;
    logic        m_ready = 1'b0;
    logic [63:0] m_rdata;

    int          errors = 0;
    int          checks = 0;
    int          mem_lat = 0;
    bit          mem_en = 1'b1;
    logic [63:0] mem_rdata = '0;

    assign m_rdata = mem_rdata;

    typedef struct {
        logic [63:0] rdata;
        bit          err;
    } rsp_t;

    typedef struct {
        bit          is_if;
        bit          we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] mrdata;
        int          lat;
        bit          mis;
        logic [31:0] e_maddr;
        logic [7:0]  e_be;
        logic [63:0] e_wdata;
        logic [63:0] e_rdata;
    } vec_t;

    rsp_t dq[$];
    rsp_t iq[$];
    vec_t tbl[$];

    mem_port_arbiter #(.STARVE_LIMIT(2), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_size(d_size), .d_wdata(d_wdata),
        .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic vec_t mk(bit is_if, bit we, logic [2:0] size, logic [31:0] addr,
                                logic [63:0] wdata, logic [63:0] mrdata, int lat, bit mis,
                                logic [31:0] e_maddr, logic [7:0] e_be, logic [63:0] e_wdata,
                                logic [63:0] e_rdata);
        vec_t v;
        v.is_if = is_if; v.we = we; v.size = size; v.addr = addr; v.wdata = wdata;
        v.mrdata = mrdata; v.lat = lat; v.mis = mis; v.e_maddr = e_maddr; v.e_be = e_be;
        v.e_wdata = e_wdata; v.e_rdata = e_rdata;
        return v;
    endfunction

    // Memory model: ready after mem_lat waited cycles while m_req is high.
    initial begin
        int mw;
        mw = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!m_req) begin
                mw = 0;
                m_ready = 1'b0;
            end else begin
                m_ready = mem_en && (mw >= mem_lat);
                mw++;
            end
        end
    end

    // Scoreboard: every completion pulse pops and compares its expected response.
    initial begin
        rsp_t r;
        forever begin
            @(posedge clk);
            #3;
            if (d_valid) begin
                if (dq.size() == 0) fail_now("d_unexpected_valid");
                else begin
                    r = dq.pop_front();
                    chk("d_rdata", d_rdata, r.rdata);
                    chk("d_err", {63'd0, d_err}, {63'd0, r.err});
                end
            end
            if (if_valid) begin
                if (iq.size() == 0) fail_now("if_unexpected_valid");
                else begin
                    r = iq.pop_front();
                    chk("if_rdata", {32'd0, if_rdata}, r.rdata);
                    chk("if_err", {63'd0, if_err}, {63'd0, r.err});
                end
            end
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        rsp_t r;
        int   cyc;
        bit   seen, done;
        mem_lat   = v.lat;
        mem_rdata = v.mrdata;
        r.rdata   = v.e_rdata;
        r.err     = v.mis;
        if (v.is_if) begin
            if_addr = v.addr; if_req = 1'b1;
            iq.push_back(r);
        end else begin
            d_we = v.we; d_size = v.size; d_addr = v.addr; d_wdata = v.wdata; d_req = 1'b1;
            dq.push_back(r);
        end
        #1;
        chk($sformatf("v%0d_stall", idx), {63'd0, v.is_if ? stall_if : stall_mem}, 64'd1);
        cyc = 0; seen = 0; done = 0;
        while (!done && cyc < 300) begin
            tick();
            cyc++;
            if (m_req && !seen) begin
                seen = 1;
                chk($sformatf("v%0d_maddr", idx), {32'd0, m_addr}, {32'd0, v.e_maddr});
                chk($sformatf("v%0d_mbe", idx), {56'd0, m_be}, {56'd0, v.e_be});
                chk($sformatf("v%0d_mwe", idx), {63'd0, m_we}, {63'd0, v.we});
                if (v.we) chk($sformatf("v%0d_mwdata", idx), m_wdata, v.e_wdata);
            end
            if (v.is_if ? if_valid : d_valid) begin
                done = 1;
                chk($sformatf("v%0d_latency", idx), 64'(cyc), v.mis ? 64'd1 : 64'(2 + v.lat));
                chk($sformatf("v%0d_mreq_seen", idx), {63'd0, seen}, {63'd0, !v.mis});
                if_req = 1'b0;
                d_req  = 1'b0;
            end
        end
        if (!done) fail_now($sformatf("v%0d_completion", idx));
        tick();
    endtask

    initial begin
        rsp_t  r;
        int    cyc, hi, n;
        bit    done, seen;
        string s_got;

        // reset state
        #3 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_m_req", {63'd0, m_req}, 64'd0);
        chk("rst_m_be", {56'd0, m_be}, 64'd0);
        chk("rst_m_addr", {32'd0, m_addr}, 64'd0);
        chk("rst_d_valid", {63'd0, d_valid}, 64'd0);
        chk("rst_if_valid", {63'd0, if_valid}, 64'd0);
        chk("rst_d_rdata", d_rdata, 64'd0);
        rst = 1'b1;
        tick();

        // single accesses: is_if we size addr wdata mrdata lat mis | maddr be wdata rdata
        tbl.push_back(mk(0, 0, 3'd2, 32'h104, 64'h0, 64'h80000001_00000000, 0, 0, 32'h100, 8'hF0, 64'h0, 64'hFFFFFFFF_80000001));
        tbl.push_back(mk(0, 1, 3'd0, 32'h203, 64'hAB, 64'h0, 0, 0, 32'h200, 8'h08, 64'hAB000000, 64'h0));
        tbl.push_back(mk(0, 0, 3'd1, 32'h101, 64'h0, 64'h0, 0, 1, 32'h0, 8'h0, 64'h0, 64'h0));
        tbl.push_back(mk(0, 0, 3'd4, 32'h105, 64'h0, 64'h00008500_00000000, 0, 0, 32'h100, 8'h20, 64'h0, 64'h85));
        tbl.push_back(mk(0, 0, 3'd0, 32'h105, 64'h0, 64'h00008500_00000000, 0, 0, 32'h100, 8'h20, 64'h0, 64'hFFFFFFFF_FFFFFF85));
        tbl.push_back(mk(0, 1, 3'd3, 32'h308, 64'h11223344_55667788, 64'h0, 0, 0, 32'h308, 8'hFF, 64'h11223344_55667788, 64'h0));
        tbl.push_back(mk(0, 1, 3'd1, 32'h206, 64'hBEEF, 64'h0, 0, 0, 32'h200, 8'hC0, 64'hBEEF0000_00000000, 64'h0));
        tbl.push_back(mk(0, 0, 3'd5, 32'h102, 64'h0, 64'h00000000_F00D0000, 0, 0, 32'h100, 8'h0C, 64'h0, 64'hF00D));
        tbl.push_back(mk(0, 0, 3'd3, 32'h10, 64'h0, 64'hDEADBEEF_CAFEF00D, 1, 0, 32'h10, 8'hFF, 64'h0, 64'hDEADBEEF_CAFEF00D));
        tbl.push_back(mk(0, 0, 3'd6, 32'h100, 64'h0, 64'h12345678_87654321, 0, 0, 32'h100, 8'h0F, 64'h0, 64'h87654321));
        tbl.push_back(mk(0, 0, 3'd7, 32'h100, 64'h0, 64'h0, 0, 1, 32'h0, 8'h0, 64'h0, 64'h0));
        tbl.push_back(mk(0, 0, 3'd3, 32'h104, 64'h0, 64'h0, 0, 1, 32'h0, 8'h0, 64'h0, 64'h0));
        tbl.push_back(mk(0, 1, 3'd2, 32'h204, 64'hCAFEBABE, 64'h0, 2, 0, 32'h200, 8'hF0, 64'hCAFEBABE_00000000, 64'h0));
        tbl.push_back(mk(1, 0, 3'd0, 32'h1004, 64'h0, 64'h13579BDF_02468ACE, 0, 0, 32'h1000, 8'hF0, 64'h0, 64'h13579BDF));
        tbl.push_back(mk(1, 0, 3'd0, 32'h1000, 64'h0, 64'h13579BDF_02468ACE, 3, 0, 32'h1000, 8'h0F, 64'h0, 64'h02468ACE));
        tbl.push_back(mk(1, 0, 3'd0, 32'h1002, 64'h0, 64'h0, 0, 1, 32'h0, 8'h0, 64'h0, 64'h0));
        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

        // both requesters held: expect D, D, I, D, D, I
        mem_lat = 0;
        mem_rdata = 64'hAAAABBBB_CCCCDDDD;
        if_addr = 32'h2000;
        d_we = 0; d_size = 3'd3; d_addr = 32'h3000;
        r.err = 0;
        r.rdata = 64'hAAAABBBB_CCCCDDDD;
        repeat (4) dq.push_back(r);
        r.rdata = 64'hCCCCDDDD;
        repeat (2) iq.push_back(r);
        if_req = 1'b1; d_req = 1'b1;
        s_got = ""; n = 0; cyc = 0;
        while (n < 6 && cyc < 40) begin
            tick();
            cyc++;
            chk($sformatf("starve_stall_if_c%0d", cyc), {63'd0, stall_if}, {63'd0, !if_valid});
            if (d_valid)  begin s_got = {s_got, "D"}; n++; end
            if (if_valid) begin s_got = {s_got, "I"}; n++; end
            if (n >= 6) begin if_req = 1'b0; d_req = 1'b0; end
        end
        if (n < 6) fail_now("starve_completions");
        checks++;
        if (s_got != "DDIDDI") begin
            errors++;
            $display("FAIL starve_order: got=%s expected=DDIDDI", s_got);
        end
        if_req = 1'b0; d_req = 1'b0;
        tick();

        // memory never ready: fetch times out after TMO cycles of m_req
        mem_en = 1'b0;
        if_addr = 32'h1000;
        r.rdata = 64'd0; r.err = 1;
        iq.push_back(r);
        if_req = 1'b1;
        hi = 0; cyc = 0; done = 0;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
            if (m_req) hi++;
            if (if_valid) begin
                done = 1;
                chk("tmo_mreq_cycles", 64'(hi), 64'(TMO));
                chk("tmo_latency", 64'(cyc), 64'(TMO + 1));
                if_req = 1'b0;
            end
        end
        if (!done) fail_now("tmo_completion");
        tick();
        mem_en = 1'b1;
        run_vec(tbl[13], 100);

        // reset in BUSY_D after 3 wait cycles; held request is re-granted
        mem_lat = 1000;
        mem_rdata = 64'h80000001_00000000;
        d_we = 0; d_size = 3'd2; d_addr = 32'h104;
        r.rdata = 64'hFFFFFFFF_80000001; r.err = 0;
        dq.push_back(r);
        d_req = 1'b1;
        cyc = 0;
        while (!m_req && cyc < 10) begin tick(); cyc++; end
        if (!m_req) fail_now("rstmid_grant");
        repeat (3) tick();
        chk("rstmid_busy_mreq", {63'd0, m_req}, 64'd1);
        rst = 1'b0;
        #1;
        chk("rstmid_mreq_cleared", {63'd0, m_req}, 64'd0);
        chk("rstmid_stall_mem", {63'd0, stall_mem}, 64'd1);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("rstmid_no_valid%0d", k), {63'd0, d_valid}, 64'd0);
        end
        mem_lat = 0;
        rst = 1'b1;
        cyc = 0; seen = 0; done = 0;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
            if (m_req && !seen) begin
                seen = 1;
                chk("rstmid_regrant_maddr", {32'd0, m_addr}, 64'h100);
                chk("rstmid_regrant_mbe", {56'd0, m_be}, 64'hF0);
            end
            if (d_valid) begin
                done = 1;
                chk("rstmid_regrant_latency", 64'(cyc), 64'd2);
                d_req = 1'b0;
            end
        end
        if (!done) fail_now("rstmid_regrant");
        repeat (2) tick();

        chk("dq_drained", 64'(dq.size()), 64'd0);
        chk("iq_drained", 64'(iq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
